// File: rtl/jpeg_dec_pkg.sv
// rtl/jpeg_dec_pkg.sv - shared JPEG scan decode constants and unstuff state type
package jpeg_dec_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SEEN_FF = 2'd1,
        MARKER  = 2'd2
    } unstuff_state_t;

    localparam logic [7:0] BYTE_FF     = 8'hFF;
    localparam logic [7:0] BYTE_STUFF  = 8'h00;
    localparam logic [7:0] MARKER_RST0 = 8'hD0;
    localparam logic [7:0] MARKER_RST1 = 8'hD1;
    localparam logic [7:0] MARKER_RST2 = 8'hD2;
    localparam logic [7:0] MARKER_RST3 = 8'hD3;
    localparam logic [7:0] MARKER_RST4 = 8'hD4;
    localparam logic [7:0] MARKER_RST5 = 8'hD5;
    localparam logic [7:0] MARKER_RST6 = 8'hD6;
    localparam logic [7:0] MARKER_RST7 = 8'hD7;
    localparam logic [7:0] MARKER_EOI  = 8'hD9;

endpackage

// File: rtl/jpeg_byte_unstuff.sv
// rtl/jpeg_byte_unstuff.sv - removes 0xFF00 stuffing, skips fill bytes, latches markers
module jpeg_byte_unstuff
    import jpeg_dec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       marker_ack,
    output logic       append_valid,
    output logic [7:0] append_byte,
    output logic       marker_hit,
    output logic [7:0] marker_code
);

    unstuff_state_t r_state;
    unstuff_state_t w_state_n;
    logic [7:0]     r_code;
    logic [7:0]     w_code_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= NORMAL;
            r_code  <= 8'h00;
        end else begin
            r_state <= w_state_n;
            r_code  <= w_code_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_code_n     = r_code;
        append_valid = 1'b0;
        append_byte  = byte_data;
        case (r_state)
            NORMAL: begin
                if (byte_valid) begin
                    if (byte_data == BYTE_FF) w_state_n = SEEN_FF;
                    else                      append_valid = 1'b1;
                end
            end
            SEEN_FF: begin
                if (byte_valid) begin
                    if (byte_data == BYTE_STUFF) begin
                        append_valid = 1'b1;
                        append_byte  = BYTE_FF;
                        w_state_n    = NORMAL;
                    end else if (byte_data != BYTE_FF) begin
                        // 0xFF repeats are fill; anything else completes a marker
                        w_code_n  = byte_data;
                        w_state_n = MARKER;
                    end
                end
            end
            MARKER: begin
                if (marker_ack) w_state_n = NORMAL;
            end
            default: w_state_n = NORMAL;
        endcase
    end

    assign marker_hit  = (r_state == MARKER);
    assign marker_code = r_code;

endmodule

// File: rtl/jpeg_scan_bit_reader.sv
// rtl/jpeg_scan_bit_reader.sv - unstuffed scan bytes into an MSB-first bit window
// Buffer is left-aligned; bits at or beyond the count are kept at zero and padded with 1s on output.
module jpeg_scan_bit_reader
    import jpeg_dec_pkg::*;
#(
    parameter int BUF_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] bits,
    output logic [4:0]  bits_avail,
    output logic        bits_valid,
    input  logic        consume_en,
    input  logic [4:0]  consume_len,
    output logic        marker_valid,
    output logic [7:0]  marker_code,
    input  logic        marker_ack,
    output logic        underflow_err
);

    logic [BUF_W-1:0] r_buf;
    logic [5:0]       r_count;
    logic             r_underflow;

    logic             w_accept;
    logic             w_append_valid;
    logic [7:0]       w_append_byte;
    logic             w_marker_hit;
    logic [7:0]       w_marker_code;
    logic             w_flush;
    logic             w_do_consume;
    logic             w_over;
    logic [5:0]       w_len;
    logic [BUF_W-1:0] w_buf_c;
    logic [5:0]       w_cnt_c;
    logic [BUF_W-1:0] w_buf_n;
    logic [5:0]       w_cnt_n;
    logic [15:0]      w_pad;

    assign w_accept = in_valid && in_ready;
    assign w_flush  = w_marker_hit && marker_ack;

    jpeg_byte_unstuff u_unstuff (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (w_accept),
        .byte_data    (in_data),
        .marker_ack   (marker_ack),
        .append_valid (w_append_valid),
        .append_byte  (w_append_byte),
        .marker_hit   (w_marker_hit),
        .marker_code  (w_marker_code)
    );

    // Consume first, then append the new byte at the post-consume tail
    always_comb begin
        w_len        = {1'b0, consume_len};
        w_do_consume = consume_en && (consume_len != 5'd0);
        w_over       = w_do_consume && (w_len > r_count);
        w_buf_c      = r_buf;
        w_cnt_c      = r_count;
        if (w_over) begin
            w_buf_c = '0;
            w_cnt_c = 6'd0;
        end else if (w_do_consume) begin
            w_buf_c = r_buf << consume_len;
            w_cnt_c = r_count - w_len;
        end
        w_buf_n = w_buf_c;
        w_cnt_n = w_cnt_c;
        if (w_append_valid) begin
            w_buf_n = w_buf_c | ({w_append_byte, {(BUF_W-8){1'b0}}} >> w_cnt_c);
            w_cnt_n = w_cnt_c + 6'd8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_buf       <= '0;
            r_count     <= 6'd0;
            r_underflow <= 1'b0;
        end else begin
            r_buf       <= w_buf_n;
            r_count     <= w_cnt_n;
            r_underflow <= w_over;
        end
    end

    assign w_pad = 16'hFFFF >> r_count;

    assign in_ready      = !rst && !w_marker_hit && (r_count <= 6'd24);
    assign bits          = rst ? 16'hFFFF : (r_buf[BUF_W-1 -: 16] | w_pad);
    assign bits_avail    = rst ? 5'd0 : ((r_count >= 6'd16) ? 5'd16 : r_count[4:0]);
    assign bits_valid    = !rst && ((r_count >= 6'd16) || (w_marker_hit && (r_count != 6'd0)));
    assign marker_valid  = !rst && w_marker_hit;
    assign marker_code   = rst ? 8'h00 : w_marker_code;
    assign underflow_err = !rst && r_underflow;

endmodule

// File: doc/jpeg_scan_bit_reader.md
JPEG_SCAN_BIT_READER -- requirements
Module: jpeg_scan_bit_reader

Interface
REQ-001 SHALL have one parameter: BUF_W, default 32, the bit-buffer width in bits; only the value 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, scan byte offered.
REQ-005 SHALL have port in_data, input, 8, entropy-coded scan byte, stuffed form.
REQ-006 SHALL have port in_ready, output, 1, byte accepted when in_valid && in_ready.
REQ-007 SHALL have port bits, output, 16, MSB-first window of the oldest unconsumed bits.
REQ-008 SHALL have port bits_avail, output, 5, number of valid bits in the window, 0..16.
REQ-009 SHALL have port bits_valid, output, 1, window is usable by the Huffman decoder.
REQ-010 SHALL have port consume_en, input, 1, decoder is consuming bits this cycle.
REQ-011 SHALL have port consume_len, input, 5, number of bits consumed, 0..16.
REQ-012 SHALL have port marker_valid, output, 1, a marker is held.
REQ-013 SHALL have port marker_code, output, 8, the second byte of the held marker.
REQ-014 SHALL have port marker_ack, input, 1, downstream has accepted the marker.
REQ-015 SHALL have port underflow_err, output, 1, one-cycle pulse on over-consume.

Function
REQ-016 SHALL be the reader/unstuffer counterpart of the scan bitstream writer: remove byte stuffing, detect markers, and present bits MSB-first.
REQ-017 SHALL hold bits in a 32-bit left-aligned buffer with a count register of 0..32.
REQ-018 SHALL drive in_ready = (state != MARKER) && (count <= 24), decoded from registers only.
REQ-019 SHALL use an unstuff FSM with states NORMAL, SEEN_FF and MARKER.
  - NORMAL, byte != 0xFF: append 8 bits.
  - NORMAL, byte == 0xFF: go to SEEN_FF, append nothing.
  - SEEN_FF, byte 0x00: append 0xFF, go to NORMAL.
  - SEEN_FF, byte 0xFF: fill byte; discard it and stay in SEEN_FF.
  - SEEN_FF, any other byte: latch marker_code, go to MARKER.
REQ-020 SHALL make an appended byte visible in bits/bits_avail on the cycle after acceptance (latency 1).
REQ-021 SHALL drive bits_avail = min(count, 16) and bits_valid = (count >= 16) || (state == MARKER && count > 0).
REQ-022 SHALL fill window positions at or beyond count with 1s (JPEG pad bits).
REQ-023 SHALL apply consume_en with 0 < consume_len <= count as count -= consume_len, with the buffer shifted left by consume_len.
REQ-024 SHALL treat consume_len == 0 as a no-op.
REQ-025 SHALL, when consume_len > count: set count to 0, empty the buffer and pulse underflow_err for one cycle.
REQ-026 SHALL, when a consume and a byte append occur in the same cycle, apply the consume first, then append at the new tail: count_next = count - len + 8.
REQ-027 SHALL assert marker_valid exactly while in MARKER, with marker_code stable throughout.
REQ-028 SHALL, on marker_ack while in MARKER, flush the buffer (count = 0, discarding pad bits) and return to NORMAL.
REQ-029 SHALL, when a consume coincides with marker_ack, let the flush win.
REQ-030 SHALL ignore marker_ack outside MARKER.
REQ-031 SHALL accept no bytes while in MARKER.

Reset
REQ-032 SHALL, while rst is high: count = 0, state = NORMAL, marker_code = 0x00, in_ready = 0, bits_valid = 0, bits_avail = 0, bits = 0xFFFF, marker_valid = 0, underflow_err = 0.
REQ-033 SHALL, on reset mid-operation (including in SEEN_FF or MARKER), discard all buffered bits and any pending marker with no output pulse.
REQ-034 SHALL raise in_ready on the first cycle after rst deasserts.

Structure
REQ-035 SHALL place the following in shared package jpeg_dec_pkg: state enum, BYTE_FF = 0xFF, BYTE_STUFF = 0x00, MARKER_RST0..RST7 = 0xD0..0xD7, MARKER_EOI = 0xD9.
REQ-036 SHALL implement the unstuff FSM as sub-module jpeg_byte_unstuff, which outputs append_valid, append_byte, marker_hit and marker_code.
REQ-037 SHALL keep the bit buffer, count and consume logic in the top level.

Verification
REQ-038 SHALL cover plain bytes: 0xA5, 0x3C -> after 2 cycles bits = 0xA53C, bits_avail = 16, bits_valid = 1.
REQ-039 SHALL cover stuffing: 0xFF, 0x00, 0x12 -> buffer holds 0xFF12, count = 16, marker_valid = 0.
REQ-040 SHALL cover a marker with pad: 0xAB, 0xFF, 0xD3 -> bits = 0xABFF, bits_avail = 8, bits_valid = 1, marker_valid = 1, marker_code = 0xD3, in_ready = 0; marker_ack -> count = 0, in_ready = 1 the next cycle.
REQ-041 SHALL cover simultaneous consume and append: count = 24, consume_len = 5 plus byte 0x80 in the same cycle -> count = 27, with the appended bits starting at bit index 19 of the buffer.
REQ-042 SHALL cover over-consume: count = 8, consume_len = 12 -> count = 0, underflow_err pulses once, bits = 0xFFFF.
REQ-043 SHALL cover fill and reset: 0xFF, 0xFF, 0xFF, 0xD9 -> marker_code = 0xD9 with no bytes appended; rst asserted while in MARKER -> marker_valid = 0 on the next cycle.
